img_dma: RTL

- Front/back-end companion to filter2d; sits on the filter's far side of the shared single-port image buffer (mem_single, 2×256×256 bytes).
- Accepts a raw image as a valid/ready byte stream and writes it into buffer region 0.
- Pulses filter2d start, waits for finish, then reads region 1 and streams the filtered image out as valid/ready bytes.
- Replaces the bench-side $readmemh/$fwrite path so the filter can run in a real system.

---
 rtl/img_dma_pkg.sv | 19 +
 rtl/img_dma_fifo2.sv | 38 +++
 rtl/img_dma.sv | 139 +++++++++++++
 3 files changed

// File: rtl/img_dma_pkg.sv
// Shared constants for the image DMA front/back-end around filter2d.
// FSM state codes, default widths and buffer region bases.
package img_dma_pkg;
    localparam int AW_DEF       = 17;
    localparam int DW_DEF       = 8;
    localparam int IMG_W        = 256;
    localparam int IMG_H        = 256;
    localparam int IMG_PIX_DEF  = IMG_W * IMG_H;
    localparam int IN_BASE_DEF  = 0;
    localparam int OUT_BASE_DEF = IMG_PIX_DEF;

    typedef logic [2:0] state_t;
    localparam state_t S_IDLE  = 3'd0;
    localparam state_t S_LOAD  = 3'd1;
    localparam state_t S_KICK  = 3'd2;
    localparam state_t S_RUN   = 3'd3;
    localparam state_t S_DRAIN = 3'd4;
    localparam state_t S_DONE  = 3'd5;
endpackage

// File: rtl/img_dma_fifo2.sv
// Two-entry synchronous FIFO used as the read-return buffer in DRAIN.
// Push and pop may occur together; flush empties it in one cycle.
module img_dma_fifo2 #(
    parameter int DW = 8
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          flush,
    input  logic          push,
    input  logic [DW-1:0] din,
    input  logic          pop,
    output logic [DW-1:0] head,
    output logic [1:0]    count
);
    logic [DW-1:0] mem [2];
    logic          wp, rp;
    logic [1:0]    cnt;

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            wp  <= 1'b0;
            rp  <= 1'b0;
            cnt <= 2'd0;
        end else begin
            if (push) wp <= ~wp;
            if (pop)  rp <= ~rp;
            cnt <= cnt + {1'b0, push} - {1'b0, pop};
        end
    end

    // Storage carries no reset; occupancy alone decides what is valid.
    always_ff @(posedge clk) begin
        if (push) mem[wp] <= din;
    end

    assign head  = mem[rp];
    assign count = cnt;
endmodule

// File: rtl/img_dma.sv
// Image DMA: streams a raw image into buffer region 0, kicks filter2d, then streams
// region 1 back out. Optional IMG_DMA_CHECKSUM_EN adds a 16-bit output checksum port.
module img_dma
    import img_dma_pkg::*;
#(
    parameter int AW       = AW_DEF,
    parameter int DW       = DW_DEF,
    parameter int IMG_PIX  = IMG_PIX_DEF,
    parameter int IN_BASE  = IN_BASE_DEF,
    parameter int OUT_BASE = OUT_BASE_DEF
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          go,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] in_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] out_data,
    output logic          f_start,
    input  logic          f_finish,
    output logic          mem_grant_f,
    output logic          mem_cs,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_din,
    input  logic [DW-1:0] mem_dout,
    output logic          busy,
    output logic          done
`ifdef IMG_DMA_CHECKSUM_EN
    ,
    output logic [15:0]   checksum
`endif
);
    localparam int            CW    = $clog2(IMG_PIX) + 1;
    localparam logic [CW-1:0] LAST  = CW'(IMG_PIX - 1);
    localparam logic [CW-1:0] NPIX  = CW'(IMG_PIX);
    localparam logic [CW-1:0] ONE   = CW'(1);
    localparam logic [AW-1:0] IN_B  = AW'(IN_BASE);
    localparam logic [AW-1:0] OUT_B = AW'(OUT_BASE);

    state_t        state;
    logic [CW-1:0] wcnt, rcnt, ocnt;
    logic          rd_pend;
    logic [1:0]    fifo_cnt;
    logic [DW-1:0] fifo_head;
    logic [2:0]    occ;
    logic          in_hs, out_hs, rd_issue, drain_go;

    assign in_ready  = (state == S_LOAD);
    assign in_hs     = in_ready && in_valid;
    assign out_valid = (state == S_DRAIN) && (fifo_cnt != 2'd0);
    assign out_hs    = out_valid && out_ready;
    assign drain_go  = (state == S_RUN) && f_finish;

    // A pop this cycle frees a slot by the time the new read returns, keeping 1 pixel/cycle.
    assign occ      = {1'b0, fifo_cnt} + {2'b0, rd_pend} - {2'b0, out_hs};
    assign rd_issue = (state == S_DRAIN) && (rcnt < NPIX) && (occ < 3'd2);

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= S_IDLE;
            wcnt    <= '0;
            rcnt    <= '0;
            ocnt    <= '0;
            rd_pend <= 1'b0;
        end else begin
            case (state)
                S_IDLE: if (go) begin
                    state <= S_LOAD;
                    wcnt  <= '0;
                end
                S_LOAD: if (in_valid) begin
                    wcnt <= wcnt + ONE;
                    if (wcnt == LAST) state <= S_KICK;
                end
                S_KICK: state <= S_RUN;
                S_RUN: if (f_finish) begin
                    state   <= S_DRAIN;
                    rcnt    <= '0;
                    ocnt    <= '0;
                    rd_pend <= 1'b0;
                end
                S_DRAIN: begin
                    rd_pend <= rd_issue;
                    if (rd_issue) rcnt <= rcnt + ONE;
                    if (out_hs) begin
                        ocnt <= ocnt + ONE;
                        if (ocnt == LAST) state <= S_DONE;
                    end
                end
                S_DONE: begin
                    state   <= S_IDLE;
                    rd_pend <= 1'b0;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    img_dma_fifo2 #(.DW(DW)) u_fifo (
        .clk   (clk),
        .reset (reset),
        .flush (drain_go),
        .push  (rd_pend),
        .din   (mem_dout),
        .pop   (out_hs),
        .head  (fifo_head),
        .count (fifo_cnt)
    );

    // Port drive is purely a function of state and handshakes, so reset zeroes it next cycle.
    always_comb begin
        mem_cs   = in_hs || rd_issue;
        mem_we   = in_hs;
        mem_addr = '0;
        mem_din  = '0;
        if (in_hs) begin
            mem_addr = IN_B + AW'(wcnt);
            mem_din  = in_data;
        end else if (rd_issue) begin
            mem_addr = OUT_B + AW'(rcnt);
        end
    end

    assign out_data    = out_valid ? fifo_head : '0;
    assign f_start     = (state == S_KICK);
    assign mem_grant_f = (state == S_KICK) || (state == S_RUN);
    assign busy        = (state != S_IDLE);
    assign done        = (state == S_DONE);

`ifdef IMG_DMA_CHECKSUM_EN
    always_ff @(posedge clk) begin
        if (reset || drain_go) checksum <= '0;
        else if (out_hs)       checksum <= checksum + 16'(out_data);
    end
`endif
endmodule
